// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/freeze sequencer.
package pipe_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational data-hazard check of the ID-stage sources against EXE/MEM destinations.
import pipe_ctrl_pkg::*;

module hazard_detect (
    input  logic             fwd_en,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             two_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    output logic             hz
);

    logic hz1;
    logic hz2;

    // With forwarding only a load in EXE cannot be bypassed in time.
    function automatic logic src_hz(input logic [REG_W-1:0] s);
        logic r;
        r = 1'b0;
        if (s != ZERO_REG) begin
            if (fwd_en)
                r = (s == exe_dest) && exe_mem_r_en;
            else
                r = ((s == exe_dest) && exe_wb_en) || ((s == mem_dest) && mem_wb_en);
        end
        return r;
    endfunction

    always_comb begin
        hz1 = src_hz(src1);
        hz2 = two_src && src_hz(src2);
        hz  = hz1 || hz2;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stall/flush priority mux, memory-wait freeze FSM with timeout trap,
// and saturating performance counters.
import pipe_ctrl_pkg::*;

// state | meaning
// RUN   | normal flow; a memory access that is not ready this cycle freezes and enters WAIT
// WAIT  | pipe frozen waiting on data memory; wcnt counts wait cycles
// ERR   | memory never answered; pipe frozen until reset
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_hold,
    output logic             if_flush,
    output logic             id_flush,
    output logic             freeze,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] TMO = WCNT_W'(MEM_TIMEOUT);

    state_t            state;
    logic [WCNT_W-1:0] wcnt;
    logic              hz;
    logic              mem_stall;

    hazard_detect u_hazard_detect (
        .fwd_en       (fwd_en),
        .src1         (id_src1),
        .src2         (id_src2),
        .two_src      (id_two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .hz           (hz)
    );

    // A dropped request while waiting counts as completion, so RUN and WAIT share one condition.
    assign mem_stall = mem_req && !mem_ready;

    always_comb begin
        freeze   = 1'b0;
        pc_hold  = 1'b0;
        if_flush = 1'b0;
        id_flush = 1'b0;
        if (rst) begin
            case (state)
                RUN, WAIT: freeze = mem_stall;
                ERR:       freeze = 1'b1;
                default:   freeze = 1'b0;
            endcase
            if (!freeze) begin
                if (br_taken) begin
                    if_flush = 1'b1;
                    id_flush = 1'b1;
                end else if (hz) begin
                    pc_hold  = 1'b1;
                    id_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            wcnt    <= '0;
            mem_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state <= WAIT;
                        wcnt  <= WCNT_W'(1);
                    end
                end
                WAIT: begin
                    if (!mem_stall) begin
                        state <= RUN;
                    end else if (wcnt == TMO) begin
                        mem_err <= 1'b1;
                        state   <= ERR;
                    end else begin
                        wcnt <= wcnt + WCNT_W'(1);
                    end
                end
                ERR:     state <= ERR;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (pc_hold && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (if_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
            if (freeze && (freeze_cnt != '1))
                freeze_cnt <= freeze_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed cases plus randomized traffic vs a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int TMO  = 4;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fwd_en, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic          br_taken, mem_req, mem_ready;
    logic [4:0]    id_src1, id_src2, exe_dest, mem_dest;
    logic          pc_hold, if_flush, id_flush, freeze, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt, freeze_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .fwd_en(fwd_en),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .br_taken(br_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_hold(pc_hold), .if_flush(if_flush), .id_flush(id_flush),
        .freeze(freeze), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference
    function automatic logic hz_src(input logic [4:0] s, input logic fe, input logic [4:0] ed,
                                    input logic ew, input logic er, input logic [4:0] md,
                                    input logic mw);
        if (s == 5'd0) return 1'b0;
        if (fe) return (s == ed) && er;
        return ((s == ed) && ew) || ((s == md) && mw);
    endfunction

    logic e_hz, e_freeze, e_pc, e_if, e_id;
    logic m_err;
    int   m_run, m_stall, m_flush, m_freeze;

    always_comb begin
        e_hz = hz_src(id_src1, fwd_en, exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en)
            || (id_two_src &&
                hz_src(id_src2, fwd_en, exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en));
        e_freeze = rst && (m_err || (mem_req && !mem_ready));
        e_pc = 1'b0;
        e_if = 1'b0;
        e_id = 1'b0;
        if (rst && !e_freeze) begin
            if (br_taken) begin
                e_if = 1'b1;
                e_id = 1'b1;
            end else if (e_hz) begin
                e_pc = 1'b1;
                e_id = 1'b1;
            end
        end
    end

    // Timeout = one initial stalled cycle plus TMO stalled wait cycles in an unbroken run.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_err <= 1'b0; m_run <= 0;
            m_stall <= 0; m_flush <= 0; m_freeze <= 0;
        end else begin
            if (e_pc     && m_stall  < MAXC) m_stall  <= m_stall + 1;
            if (e_if     && m_flush  < MAXC) m_flush  <= m_flush + 1;
            if (e_freeze && m_freeze < MAXC) m_freeze <= m_freeze + 1;
            if (!m_err && mem_req && !mem_ready) begin
                m_run <= m_run + 1;
                if (m_run + 1 == TMO + 1) m_err <= 1'b1;
            end else begin
                m_run <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pc_hold",    pc_hold,    e_pc);
            chk("if_flush",   if_flush,   e_if);
            chk("id_flush",   id_flush,   e_id);
            chk("freeze",     freeze,     e_freeze);
            chk("mem_err",    mem_err,    m_err);
            chk("stall_cnt",  stall_cnt,  m_stall);
            chk("flush_cnt",  flush_cnt,  m_flush);
            chk("freeze_cnt", freeze_cnt, m_freeze);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fwd_en = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
        exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0;
        mem_dest = 0; mem_wb_en = 0; br_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        #12;
        rst = 1'b1;
        step();
    endtask

    initial begin
        idle();
        rst = 1'b0;
        #3;
        cmp_en = 1'b1;
        do_reset();

        chk("rst_pc_hold", pc_hold, 0);
        chk("rst_freeze", freeze, 0);
        chk("rst_mem_err", mem_err, 0);
        chk("rst_stall_cnt", stall_cnt, 0);

        // 1: no-forwarding RAW stall
        fwd_en = 0; id_src1 = 3; exe_dest = 3; exe_wb_en = 1;
        #3;
        chk("t1_pc_hold", pc_hold, 1);
        chk("t1_id_flush", id_flush, 1);
        chk("t1_if_flush", if_flush, 0);
        step(); idle(); #3;
        chk("t1_stall_cnt", stall_cnt, 1);
        chk("t1_pc_hold_after", pc_hold, 0);

        // 2: load-use with forwarding
        fwd_en = 1; id_src2 = 5; id_two_src = 1; exe_dest = 5; exe_mem_r_en = 1;
        #3;
        chk("t2_loaduse", pc_hold, 1);
        step();
        exe_mem_r_en = 0; exe_wb_en = 1; #1;
        chk("t2_fwd_no_load", pc_hold, 0);
        chk("t2_stall_cnt", stall_cnt, 2);
        id_src1 = 0; id_two_src = 0; exe_dest = 0; exe_mem_r_en = 1; #1;
        chk("t2_r0_fwd", pc_hold, 0);
        fwd_en = 0; #1;
        chk("t2_r0_nofwd", pc_hold, 0);
        step(); idle();

        // 3: branch beats hazard
        id_src1 = 7; exe_dest = 7; exe_wb_en = 1; br_taken = 1;
        #3;
        chk("t3_if_flush", if_flush, 1);
        chk("t3_id_flush", id_flush, 1);
        chk("t3_pc_hold", pc_hold, 0);
        step(); idle(); #3;
        chk("t3_flush_cnt", flush_cnt, 1);

        // 4: three-cycle memory wait with a hazard present
        do_reset();
        for (int i = 0; i < 3; i++) begin
            mem_req = 1; mem_ready = 0; id_src1 = 2; mem_dest = 2; mem_wb_en = 1;
            #3;
            chk("t4_freeze", freeze, 1);
            chk("t4_pc_hold_frozen", pc_hold, 0);
            step();
        end
        idle(); mem_req = 1; mem_ready = 1; #3;
        chk("t4_freeze_release", freeze, 0);
        step(); idle(); #3;
        chk("t4_freeze_cnt", freeze_cnt, 3);

        // 5: timeout trap and async clear
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) step();
        chk("t5_no_err_yet", mem_err, 0);
        step();
        chk("t5_mem_err", mem_err, 1);
        chk("t5_freeze_cnt", freeze_cnt, 5);
        mem_req = 0; #3;
        chk("t5_err_freeze", freeze, 1);
        rst = 1'b0; #1;
        chk("t5_rst_mem_err", mem_err, 0);
        chk("t5_rst_freeze", freeze, 0);
        chk("t5_rst_freeze_cnt", freeze_cnt, 0);
        step(); rst = 1'b1;

        // reset in the middle of WAIT restarts the wait count
        mem_req = 1; mem_ready = 0;
        step(); step();
        rst = 1'b0; #1;
        chk("mw_rst_freeze", freeze, 0);
        step(); rst = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("mw_no_err_yet", mem_err, 0);
        step();
        chk("mw_mem_err", mem_err, 1);

        // 6: counter saturation
        do_reset();
        fwd_en = 0; id_src1 = 1; exe_dest = 1; exe_wb_en = 1;
        for (int i = 0; i < 20; i++) step();
        chk("t6_stall_sat", stall_cnt, 15);
        idle();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            step();
            rst          = ($urandom_range(0, 119) != 0);
            fwd_en       = $urandom_range(0, 1);
            id_src1      = 5'($urandom_range(0, 3));
            id_src2      = 5'($urandom_range(0, 3));
            id_two_src   = $urandom_range(0, 1);
            exe_dest     = 5'($urandom_range(0, 3));
            exe_wb_en    = $urandom_range(0, 1);
            exe_mem_r_en = ($urandom_range(0, 2) == 0);
            mem_dest     = 5'($urandom_range(0, 3));
            mem_wb_en    = $urandom_range(0, 1);
            br_taken     = ($urandom_range(0, 7) == 0);
            mem_req      = ($urandom_range(0, 9) < 6);
            mem_ready    = ($urandom_range(0, 9) < 4);
        end
        step();
        rst = 1'b1;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
